// File: rtl/ppa_sklansky_sub_pipe_pkg.sv
// Shared constants for the pipelined Sklansky subtractor: default width and stage-occupancy encoding.
// Package only: no latency, no handshake.
// Imported by the pipeline top and the prefix tree.
package ppa_sklansky_sub_pipe_pkg;

    localparam int WIDTH_DEF = 49;

    typedef enum logic {
        STG_EMPTY = 1'b0,
        STG_FULL  = 1'b1
    } stg_t;

    function automatic logic stg_is_full(input stg_t st);
        return st == STG_FULL;
    endfunction

endpackage

// File: rtl/sklansky_gp_tree.sv
// Sklansky parallel-prefix tree: maps per-bit p/g to group P/G spanning [i:0] for every bit i.
// Latency: purely combinational, log2(width) levels.
// Backpressure: none (no state).
module sklansky_gp_tree
    import ppa_sklansky_sub_pipe_pkg::*;
#(
    parameter int width = WIDTH_DEF
) (
    input  logic [width-1:0] p,
    input  logic [width-1:0] g,
    output logic [width-1:0] P,
    output logic [width-1:0] G
);

    localparam int LEVELS = (width > 1) ? $clog2(width) : 1;

    for (genvar l = 0; l < LEVELS; l++) begin : lvl
        logic [width-1:0] p_in;
        logic [width-1:0] g_in;
        logic [width-1:0] p_out;
        logic [width-1:0] g_out;

        if (l == 0) begin : g_first
            assign p_in = p;
            assign g_in = g;
        end else begin : g_next
            assign p_in = lvl[l-1].p_out;
            assign g_in = lvl[l-1].g_out;
        end

        for (genvar i = 0; i < width; i++) begin : bitn
            // Bits in the upper half of each 2^(l+1) block absorb the top of the lower half.
            if (((i >> l) & 1) == 1) begin : g_comb
                localparam int J = ((i >> l) << l) - 1;
                assign p_out[i] = p_in[i] & p_in[J];
                assign g_out[i] = g_in[i] | (p_in[i] & g_in[J]);
            end else begin : g_pass
                assign p_out[i] = p_in[i];
                assign g_out[i] = g_in[i];
            end
        end
    end

    assign P = lvl[LEVELS-1].p_out;
    assign G = lvl[LEVELS-1].g_out;

endmodule

// File: rtl/ppa_sklansky_sub_pipe.sv
// Two-stage pipelined subtractor D = A - B - bin with borrow, signed overflow and zero flags.
// Latency: 2 cycles from input acceptance to out_valid; 1 beat/cycle sustained.
// Backpressure: valid/ready; a stage loads only when empty or draining, in_ready drops when both stages are stuck.
module ppa_sklansky_sub_pipe
    import ppa_sklansky_sub_pipe_pkg::*;
#(
    parameter int width = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] D,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    logic [width-1:0] p_in;
    logic [width-1:0] g_in;
    logic [width-1:0] p_grp;
    logic [width-1:0] g_grp;

    // Subtraction as A + ~B + ~bin.
    assign p_in = A ^ ~B;
    assign g_in = A & ~B;

    sklansky_gp_tree #(.width(width)) u_tree (
        .p (p_in),
        .g (g_in),
        .P (p_grp),
        .G (g_grp)
    );

    stg_t             s1_st;
    stg_t             s2_st;
    logic [width-1:0] s1_p;
    logic [width-1:0] s1_P;
    logic [width-1:0] s1_G;
    logic             s1_c0;

    logic             s1_vld;
    logic             s2_vld;
    logic             s2_load;
    logic             in_fire;

    assign s1_vld    = stg_is_full(s1_st);
    assign s2_vld    = stg_is_full(s2_st);
    assign s2_load   = s1_vld && (!s2_vld || out_ready);
    assign in_ready  = !rst && (!s1_vld || s2_load);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_vld;

    logic [width:0]   carry;
    logic [width-1:0] d_nxt;

    assign carry[0]       = s1_c0;
    assign carry[width:1] = s1_G | (s1_P & {width{s1_c0}});
    assign d_nxt          = s1_p ^ carry[width-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_st <= STG_EMPTY;
            s1_p  <= '0;
            s1_P  <= '0;
            s1_G  <= '0;
            s1_c0 <= 1'b0;
        end else if (in_fire) begin
            s1_st <= STG_FULL;
            s1_p  <= p_in;
            s1_P  <= p_grp;
            s1_G  <= g_grp;
            s1_c0 <= ~bin;
        end else if (s2_load) begin
            s1_st <= STG_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_st <= STG_EMPTY;
            D     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (s2_load) begin
            s2_st <= STG_FULL;
            D     <= d_nxt;
            bout  <= ~carry[width];
            ovf   <= carry[width] ^ carry[width-1];
            zero  <= ~|d_nxt;
        end else if (out_ready) begin
            s2_st <= STG_EMPTY;
        end
    end

endmodule

// File: tb/tb_ppa_sklansky_sub_pipe.sv
// Bench for ppa_sklansky_sub_pipe: directed vectors, stall/stream, reset flush and random traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_ppa_sklansky_sub_pipe;

    localparam int W = 49;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         bout;
    logic         ovf;
    logic         zero;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    exp_t         sb[$];
    logic         hold_vld = 1'b0;
    exp_t         hold_val;

    always #5 clk = ~clk;

    ppa_sklansky_sub_pipe #(.width(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Plain-arithmetic reference: unsigned difference for D/bout, signed range test for ovf.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t        r;
        logic [W:0]  diff;
        longint      sa;
        longint      sb_v;
        longint      sr;
        longint      maxp;
        diff   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        sa     = longint'({{(64-W){a[W-1]}}, a});
        sb_v   = longint'({{(64-W){b[W-1]}}, b});
        sr     = sa - sb_v - longint'({63'd0, bi});
        maxp   = (longint'(1) <<< (W-1)) - 1;
        r.d    = diff[W-1:0];
        r.bout = diff[W];
        r.ovf  = (sr > maxp) || (sr < -maxp - 1);
        r.zero = (diff[W-1:0] == '0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: settle, check handshake and scoreboard, then advance to the next falling edge.
    task automatic tick(output logic acc);
        exp_t e;
        #1;
        acc = 1'b0;
        if (rst) begin
            check("in_ready_in_rst", 64'(in_ready), 64'(0));
        end else begin
            check("in_ready", 64'(in_ready), 64'((sb.size() < 2) || out_ready));
            if (hold_vld) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_D", 64'(D), 64'(hold_val.d));
                check("hold_flags", 64'({bout, ovf, zero}), 64'({hold_val.bout, hold_val.ovf, hold_val.zero}));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    check("D", 64'(D), 64'(e.d));
                    check("bout", 64'(bout), 64'(e.bout));
                    check("ovf", 64'(ovf), 64'(e.ovf));
                    check("zero", 64'(zero), 64'(e.zero));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(A, B, bin));
                acc = 1'b1;
            end
            hold_vld = out_valid && !out_ready;
            hold_val = '{d: D, bout: bout, ovf: ovf, zero: zero};
        end
        if (rst) begin
            sb.delete();
            hold_vld = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                              input logic [W-1:0] ed, input logic eb, input logic eo, input logic ez);
        logic acc;
        int   lat;
        A = a; B = b; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
        tick(acc);
        check("single_accept", 64'(acc), 64'(1));
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick(acc);
            lat++;
        end
        check("latency", 64'(lat), 64'(2));
        check("dir_D", 64'(D), 64'(ed));
        check("dir_flags", 64'({bout, ovf, zero}), 64'({eb, eo, ez}));
        tick(acc);
    endtask

    initial begin
        logic         acc;
        logic [W-1:0] ra[8];
        logic [W-1:0] rb[8];
        logic         rbi[8];
        int           sent;
        int           cyc;
        int           stalls;
        int           out0;

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        A = '0; B = '0; bin = 1'b0;
        @(negedge clk);
        tick(acc);
        tick(acc);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_D", 64'(D), 64'(0));
        check("rst_flags", 64'({bout, ovf, zero}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);

        run_single(49'd5, 49'd3, 1'b0, 49'd2, 1'b0, 1'b0, 1'b0);
        run_single(49'd0, 49'd1, 1'b0, 49'h1_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_single(49'h0_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF, 1'b0, 49'h1_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        run_single(49'h123, 49'h123, 1'b0, 49'd0, 1'b0, 1'b0, 1'b1);
        run_single(49'h123, 49'h123, 1'b1, 49'h1_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_single(49'h1_0000_0000_0000, 49'd1, 1'b0, 49'h0_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream with the consumer stalled for cycles 3..6.
        for (int i = 0; i < 8; i++) begin
            ra[i]  = W'({$urandom(), $urandom()});
            rb[i]  = W'({$urandom(), $urandom()});
            rbi[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; cyc = 0; stalls = 0; out0 = n_out;
        while ((sent < 8 || sb.size() > 0) && cyc < 100) begin
            in_valid  = (sent < 8);
            if (sent < 8) begin
                A = ra[sent]; B = rb[sent]; bin = rbi[sent];
            end
            out_ready = !(cyc >= 3 && cyc <= 6);
            #0;
            if (in_valid && !in_ready) stalls++;
            tick(acc);
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_done", 64'(cyc < 100), 64'(1));
        check("stream_count", 64'(n_out - out0), 64'(8));
        check("stream_stalled", 64'(stalls > 0), 64'(1));

        // Reset with two beats in flight: they must vanish.
        out_ready = 1'b1; in_valid = 1'b1;
        A = 49'd77; B = 49'd11; bin = 1'b0;
        tick(acc);
        A = 49'd99; B = 49'd1; bin = 1'b1;
        tick(acc);
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_D", 64'(D), 64'(0));
        @(negedge clk);
        out0 = n_out;
        run_single(49'd1000, 49'd1, 1'b1, 49'd998, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(acc);
        check("flush_only_new", 64'(n_out - out0), 64'(1));

        // Random valid/ready traffic, then drain.
        out0 = n_out; sent = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            A = W'({$urandom(), $urandom()});
            B = (i % 7 == 0) ? A : W'({$urandom(), $urandom()});
            bin = 1'($urandom_range(0, 1));
            tick(acc);
            if (acc) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sb.size() > 0 && cyc < 20) begin
            tick(acc);
            cyc++;
        end
        check("random_drain", 64'(sb.size()), 64'(0));
        check("random_count", 64'(n_out - out0), 64'(sent));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppa_sklansky_sub_pipe.md
PPA_SKLANSKY_SUB_PIPE -- requirements
Module: ppa_sklansky_sub_pipe

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter: width, 49, operand and difference width in bits.
REQ-003 The block SHALL have port: clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port: rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port: in_valid  input  1  operand beat present.
REQ-006 The block SHALL have port: in_ready  output  1  block accepts a beat this cycle.
REQ-007 The block SHALL have port: A  input  width  minuend.
REQ-008 The block SHALL have port: B  input  width  subtrahend.
REQ-009 The block SHALL have port: bin  input  1  borrow-in.
REQ-010 The block SHALL have port: out_valid  output  1  result beat present.
REQ-011 The block SHALL have port: out_ready  input  1  consumer accepts a result beat.
REQ-012 The block SHALL have port: D  output  width  difference A - B - bin mod 2^width.
REQ-013 The block SHALL have port: bout  output  1  borrow-out, 1 when unsigned A < B + bin.
REQ-014 The block SHALL have port: ovf  output  1  two's-complement signed overflow of the subtraction.
REQ-015 The block SHALL have port: zero  output  1  1 when D == 0.

Function
REQ-016 A beat SHALL transfer on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-017 Arithmetic SHALL be A + ~B + ~bin using per-bit p = A ^ ~B and g = A & ~B, with Sklansky prefix group P/G over all width bits.
REQ-018 Stage 1 SHALL register p, prefix P, prefix G and ~bin; stage 2 SHALL register D, bout, ovf and zero.
REQ-019 Carry c[i+1] SHALL equal G[i] | (P[i] & c[0]) with c[0] = ~bin; D = p ^ c[width-1:0]; bout = ~c[width]; ovf = c[width] ^ c[width-1].
REQ-020 Latency SHALL be exactly 2 cycles from input acceptance to out_valid with out_ready held high; sustained throughput SHALL be 1 beat per cycle.
REQ-021 Each stage SHALL load when it is empty or its contents are leaving the same cycle; otherwise it SHALL hold its contents unchanged.
REQ-022 in_ready SHALL equal !s1_valid || (s1 advancing into stage 2), combinational from out_ready, with no combinational path from in_valid to in_ready.
REQ-023 When out_ready is low with both stages full, in_ready SHALL be low and D/bout/ovf/zero SHALL be held stable.
REQ-024 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-025 Data outputs SHALL be don't-care while out_valid is low.

Reset
REQ-026 While rst is high at a clock edge, both stage valids SHALL clear; out_valid = 0, D = 0, bout = 0, ovf = 0, zero = 0 after that edge.
REQ-027 While rst is high, in_ready SHALL be low and no input beat SHALL be accepted.
REQ-028 rst asserted mid-operation SHALL discard all in-flight beats; the first beat accepted after rst deasserts SHALL appear 2 cycles later.

Structure
REQ-029 The default width (49) and the stage-valid encoding SHALL live in a shared package.
REQ-030 The Sklansky prefix network SHALL be one sub-module, sklansky_gp_tree, parameterised by width, mapping p,g to P,G combinationally.
REQ-031 Only the pipeline registers and handshake logic SHALL reside in ppa_sklansky_sub_pipe.

Verification
REQ-032 A=5, B=3, bin=0, out_ready=1 -> 2 cycles later D=2, bout=0, ovf=0, zero=0.
REQ-033 A=0, B=1, bin=0 -> D=0x1_FFFF_FFFF_FFFF, bout=1, ovf=0, zero=0.
REQ-034 A=0x0_FFFF_FFFF_FFFF, B=0x1_FFFF_FFFF_FFFF, bin=0 -> D=0x1_0000_0000_0000, bout=1, ovf=1; A=B=0x123, bin=0 -> D=0, zero=1, bout=0.
REQ-035 Stream 8 random beats back-to-back with out_ready low for cycles 3-6 -> in_ready low after both stages fill, outputs held stable, all 8 results in order and match reference model.
REQ-036 Assert rst for 1 cycle while 2 beats are in flight -> out_valid=0 next cycle, the flushed beats never appear, the next accepted beat emerges after exactly 2 cycles.
